// File: rtl/rv32i_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_wb_master
// Brief    : RV32I load/store unit front-end driving a Wishbone classic bus.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_wb_master #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // load/store request channel
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_wdata_i,
    // response channel
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    // Wishbone classic master
    input  logic [XLEN-1:0] master_dat_i,
    output logic [XLEN-1:0] master_dat_o,
    output logic [XLEN-3:0] adr_o,
    output logic [3:0]      sel_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    input  logic            ack_i,
    input  logic            err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next_state;

    logic [XLEN-1:0] r_addr;
    logic [1:0]      r_size;
    logic            r_we;
    logic            r_uns;
    logic [XLEN-1:0] r_wdata;
    logic            r_err;
    logic [XLEN-1:0] r_rdata;
    logic [7:0]      r_cnt;
    logic            r_cyc;

    logic            w_accept;
    logic            w_misaligned;
    logic            w_bus_done;
    logic            w_timeout;
    logic [3:0]      w_sel;
    logic [XLEN-1:0] w_wdat;
    logic [4:0]      w_lane_sh;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_ext;

    assign w_accept     = (r_state == S_IDLE) && req_valid_i;
    assign w_misaligned = (req_size_i == 2'b11)
                       || ((req_size_i == 2'b01) && req_addr_i[0])
                       || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign w_bus_done   = ack_i || err_i;
    assign w_timeout    = (r_cnt == C_TMO_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req_valid_i) w_next_state = w_misaligned ? S_RESP : S_BUS;
            S_BUS:   if (w_bus_done || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte-lane enables and store-data replication from the captured request
    always_comb begin
        w_sel  = 4'b0000;
        w_wdat = r_wdata;
        case (r_size)
            2'b00: begin
                w_sel  = 4'b0001 << r_addr[1:0];
                w_wdat = {(XLEN/8){r_wdata[7:0]}};
            end
            2'b01: begin
                w_sel  = 4'b0011 << r_addr[1:0];
                w_wdat = {(XLEN/16){r_wdata[15:0]}};
            end
            default: begin
                w_sel  = 4'b1111;
                w_wdat = r_wdata;
            end
        endcase
    end

    assign w_lane_sh = {r_addr[1:0], 3'b000};
    assign w_shifted = master_dat_i >> w_lane_sh;

    always_comb begin
        w_load_ext = w_shifted;
        case (r_size)
            2'b00:   w_load_ext = {{(XLEN-8){~r_uns & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_ext = {{(XLEN-16){~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= 8'd0;
            r_cyc   <= 1'b0;
        end else begin
            r_cyc <= (w_next_state == S_BUS);
            if (w_accept) begin
                r_addr  <= req_addr_i;
                r_size  <= req_size_i;
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_wdata <= req_wdata_i;
                r_err   <= w_misaligned;
                r_rdata <= '0;
                r_cnt   <= 8'd0;
            end else if (r_state == S_BUS) begin
                // Simultaneous ack and err is reported as an error
                if (w_bus_done) begin
                    r_err   <= err_i;
                    r_rdata <= (err_i || r_we) ? '0 : w_load_ext;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign cyc_o        = r_cyc;
    assign stb_o        = r_cyc;
    assign we_o         = r_cyc & r_we;
    assign adr_o        = r_cyc ? r_addr[XLEN-1:2] : '0;
    assign sel_o        = r_cyc ? w_sel : 4'b0000;
    assign master_dat_o = r_cyc ? w_wdat : '0;

    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_err_o    = rsp_valid_o & r_err;
    assign rsp_rdata_o  = rsp_valid_o ? r_rdata : '0;

endmodule
`default_nettype wire
